// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Glyph codes, message length, sequencer state encoding and the
//               message ROM lookup. Shared by the glyph decoder and the
//               message sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Glyph codes understood by the 2-bit seven-segment decoder
    localparam logic [1:0] CODE_D     = 2'b00;
    localparam logic [1:0] CODE_E     = 2'b01;
    localparam logic [1:0] CODE_ONE   = 2'b10;
    localparam logic [1:0] CODE_BLANK = 2'b11;

    localparam int         SEQ_LEN    = 5;
    localparam logic [2:0] LAST_IDX   = 3'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

    // Message "d E E 1 <blank>"
    function automatic logic [1:0] msg_rom(input logic [2:0] idx);
        logic [1:0] code;
        case (idx)
            3'd0:    code = CODE_D;
            3'd1:    code = CODE_E;
            3'd2:    code = CODE_E;
            3'd3:    code = CODE_ONE;
            default: code = CODE_BLANK;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronizes and debounces one raw active-low push-button.
//               A new level is accepted only after DB_CYCLES consecutive
//               identical synchronized samples; a press (1->0 of the
//               debounced level) yields a one-cycle pulse.
// Ports       : CLOCK_50 (in)  system clock
//               rst      (in)  asynchronous active-high reset
//               key_n    (in)  raw button, active-low, asynchronous
//               level    (out) debounced level (1 = released)
//               press    (out) one-cycle pulse on debounced press
// Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Pulse is registered from the level edge, one cycle after
            // the debounced level itself changes.
            r_press   <= r_level_d & ~r_level;
            // Count samples that disagree with the accepted level; any
            // agreeing sample means the input bounced back, so restart.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/seg_msg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : seg_msg_sequencer
// Description : Steps the message "d E E 1 <blank>" onto the glyph decoder's
//               2-bit select, either free-running at one step every
//               STEP_CYCLES clocks or single-stepped while paused.
// Ports       : CLOCK_50   (in)  system clock
//               rst        (in)  asynchronous active-high reset
//               key_run_n  (in)  raw RUN/PAUSE button, active-low
//               key_step_n (in)  raw STEP button, active-low
//               seg_code   (out) glyph code to the decoder
//               seq_idx    (out) current message index 0..4
//               running    (out) 1 while in RUN
//               wrap       (out) one-cycle pulse on index 4->0
// Revision    : 1.0  initial release
// ============================================================================
module seg_msg_sequencer #(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int DB_CYCLES   = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       key_run_n,
    input  logic       key_step_n,
    output logic [1:0] seg_code,
    output logic [2:0] seq_idx,
    output logic       running,
    output logic       wrap
);

    import seg_pkg::*;

    localparam int                 c_PRE_W    = $clog2(STEP_CYCLES);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(STEP_CYCLES - 1);

    logic w_run_press;
    logic w_step_press;
    logic w_run_level;
    logic w_step_level;
    logic w_unused_levels;

    seq_state_t         r_state;
    seq_state_t         w_state;
    logic [c_PRE_W-1:0] r_presc;
    logic [c_PRE_W-1:0] w_presc;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx;
    logic [1:0]         r_seg;
    logic [1:0]         w_seg;
    logic               r_wrap;
    logic               w_wrap;
    logic               w_adv;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .key_n    (key_run_n),
        .level    (w_run_level),
        .press    (w_run_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .key_n    (key_step_n),
        .level    (w_step_level),
        .press    (w_step_press)
    );

    // Only the press pulses drive the sequencer; levels are left unused.
    assign w_unused_levels = w_run_level ^ w_step_level;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= CODE_BLANK;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_presc <= w_presc;
            r_idx   <= w_idx;
            r_seg   <= w_seg;
            r_wrap  <= w_wrap;
        end
    end

    always_comb begin
        w_state = r_state;
        w_presc = r_presc;
        w_idx   = r_idx;
        w_adv   = 1'b0;
        w_wrap  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_run_press) begin
                    w_state = RUN;
                    w_presc = '0;
                    w_idx   = '0;
                end
            end
            RUN: begin
                if (r_presc == c_PRE_LAST) begin
                    w_presc = '0;
                    w_adv   = 1'b1;
                end else begin
                    w_presc = r_presc + c_PRE_W'(1);
                end
                // Pausing freezes the count where it stands, unless this is
                // the terminal cycle, in which case the step still happens.
                if (w_run_press) begin
                    w_state = PAUSE;
                    if (!w_adv) begin
                        w_presc = r_presc;
                    end
                end
            end
            PAUSE: begin
                // Run wins over a coincident step press.
                if (w_run_press) begin
                    w_state = RUN;
                end else if (w_step_press) begin
                    w_adv = 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        if (w_adv) begin
            if (r_idx == LAST_IDX) begin
                w_idx  = '0;
                w_wrap = 1'b1;
            end else begin
                w_idx = r_idx + 3'd1;
            end
        end

        w_seg = (w_state == IDLE) ? CODE_BLANK : msg_rom(w_idx);
    end

    assign seg_code = r_seg;
    assign seq_idx  = r_idx;
    assign running  = (r_state == RUN);
    assign wrap     = r_wrap;

endmodule
`default_nettype wire
